// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM generator and demodulator.
package pdm_pkg;

    localparam int unsigned PDM_WIDTH = 5;

    function automatic int unsigned pdm_window_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

    typedef enum logic {
        IDLE,
        ACCUM
    } pdm_dem_state_t;

endpackage

// File: rtl/pdm_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; SYNC_STAGES must be at least 2.
module pdm_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pdm_i,
    output logic bit_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_i};
        end
    end

    assign bit_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pdm_demodulator.sv
// PDM to PCM demodulator: counts ones over a 2^WIDTH-cycle window and emits a saturated
// sample on a valid/ready handshake with a sticky overrun flag.
module pdm_demodulator
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH       = PDM_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pdm_in,
    output logic [WIDTH-1:0] pcm_out,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    localparam int unsigned      WinLen  = pdm_window_len(WIDTH);
    localparam logic [WIDTH-1:0] CntLast = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntOne  = {{(WIDTH-1){1'b0}}, 1'b1};

    pdm_dem_state_t   state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] pcm_out_q, pcm_out_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             overrun_q, overrun_d;
    logic             bit_s;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             window_end;
    logic             transfer;

    pdm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .pdm_i  (pdm_in),
        .bit_o  (bit_s)
    );

    assign sum      = acc_q + {{WIDTH{1'b0}}, bit_s};
    // A full window of ones (2^WIDTH) does not fit the sample width; clamp to all-ones.
    assign sat      = (32'(sum) >= WinLen) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign transfer = pcm_valid_q && pcm_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        pcm_out_d   = pcm_out_q;
        pcm_valid_d = pcm_valid_q;
        overrun_d   = overrun_q;
        window_end  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                if (enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    acc_d = sum;
                    if (cnt_q == CntLast) begin
                        window_end = 1'b1;
                        acc_d      = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            pcm_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        // A coincident transfer drains the old sample, so only an unaccepted one is lost.
        if (window_end) begin
            pcm_out_d   = sat;
            pcm_valid_d = 1'b1;
            overrun_d   = pcm_valid_q && !pcm_ready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pcm_out_q   <= pcm_out_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm_out   = pcm_out_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_demodulator.sv
// Directed bench for pdm_demodulator: first-order encoder stimulus, table of levels, and
// hand-written sequences for overrun, coincident transfer, enable drop and reset.
module tb_pdm_demodulator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       pdm_in = 1'b0;
    logic [4:0] pcm_out;
    logic       pcm_valid;
    logic       pcm_ready = 1'b1;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // 0: first-order encoder at `level`, 1: constant 0, 2: constant 1
    int         src_mode = 1;
    logic [4:0] level = 5'd0;
    logic [4:0] enc_acc = 5'd0;

    typedef struct {
        int         mode;
        logic [4:0] lvl;
        logic [4:0] exp_pcm;
    } vec_t;

    vec_t vecs [8];

    pdm_demodulator dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .pdm_in   (pdm_in),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One rising edge, then drive the next stream bit 1 time unit later.
    task automatic step();
        logic [5:0] s;
        @(posedge clk);
        #1;
        case (src_mode)
            0: begin
                s       = {1'b0, enc_acc} + {1'b0, level};
                enc_acc = s[4:0];
                pdm_in  = s[5];
            end
            1: pdm_in = 1'b0;
            default: pdm_in = 1'b1;
        endcase
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pcm_valid && n < 40);
        check(name, 32'(pcm_valid), 32'd1);
    endtask

    initial begin
        int n;

        vecs[0] = '{0, 5'h08, 5'd8};
        vecs[1] = '{0, 5'h1a, 5'd26};
        vecs[2] = '{0, 5'h0f, 5'd15};
        vecs[3] = '{0, 5'h04, 5'd4};
        vecs[4] = '{1, 5'h00, 5'd0};
        vecs[5] = '{2, 5'h00, 5'd31};
        vecs[6] = '{0, 5'h1f, 5'd31};
        vecs[7] = '{0, 5'h01, 5'd1};

        // Reset state
        step();
        step();
        check("reset_pcm_out", 32'(pcm_out), 32'd0);
        check("reset_pcm_valid", 32'(pcm_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Level table: third sample after a source change is from a clean window
        for (int i = 0; i < 8; i++) begin
            src_mode = vecs[i].mode;
            level    = vecs[i].lvl;
            wait_valid("tbl_wait1", n);
            wait_valid("tbl_wait2", n);
            wait_valid("tbl_wait3", n);
            check("tbl_period", 32'(n), 32'd32);
            check("tbl_pcm_out", 32'(pcm_out), 32'(vecs[i].exp_pcm));
            check("tbl_overrun", 32'(overrun), 32'd0);
        end

        // Overrun: consumer stalls for three window ends
        src_mode = 0;
        level    = 5'h08;
        wait_valid("ovr_settle1", n);
        wait_valid("ovr_settle2", n);
        wait_valid("ovr_settle3", n);
        step();
        pcm_ready = 1'b0;
        wait_valid("ovr_first", n);
        check("ovr_first_pcm", 32'(pcm_out), 32'd8);
        check("ovr_first_flag", 32'(overrun), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 16) check("ovr_hold_valid", 32'(pcm_valid), 32'd1);
            if (k == 31) check("ovr_before_end", 32'(overrun), 32'd0);
        end
        check("ovr_second_flag", 32'(overrun), 32'd1);
        check("ovr_second_valid", 32'(pcm_valid), 32'd1);
        check("ovr_second_pcm", 32'(pcm_out), 32'd8);
        for (int k = 1; k <= 32; k++) step();
        check("ovr_third_flag", 32'(overrun), 32'd1);
        check("ovr_third_pcm", 32'(pcm_out), 32'd8);
        step();
        step();
        step();
        pcm_ready = 1'b1;
        step();
        pcm_ready = 1'b0;
        check("ovr_drain_valid", 32'(pcm_valid), 32'd0);
        check("ovr_drain_flag", 32'(overrun), 32'd0);

        // Transfer coincident with a window end while overrun is set
        pcm_ready = 1'b1;
        level     = 5'h1a;
        wait_valid("coin_settle1", n);
        wait_valid("coin_settle2", n);
        wait_valid("coin_settle3", n);
        step();
        pcm_ready = 1'b0;
        wait_valid("coin_first", n);
        for (int k = 1; k <= 32; k++) step();
        check("coin_pre_overrun", 32'(overrun), 32'd1);
        for (int k = 1; k <= 31; k++) step();
        pcm_ready = 1'b1;
        step();
        check("coin_valid", 32'(pcm_valid), 32'd1);
        check("coin_pcm", 32'(pcm_out), 32'd26);
        check("coin_overrun", 32'(overrun), 32'd0);
        step();
        check("coin_after_valid", 32'(pcm_valid), 32'd0);

        // Enable dropped at cycle 17 of a window, raised again 5 cycles later
        level = 5'h08;
        wait_valid("en_settle1", n);
        wait_valid("en_settle2", n);
        for (int k = 1; k <= 17; k++) step();
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("en_idle_valid", 32'(pcm_valid), 32'd0);
        end
        enable = 1'b1;
        // 1 idle cycle with enable sampled + 32 window cycles; sample visible in the 34th cycle
        wait_valid("en_restart", n);
        check("en_restart_latency", 32'(n), 32'd33);
        check("en_restart_pcm", 32'(pcm_out), 32'd8);

        // Asynchronous reset mid-window with a pending sample
        pcm_ready = 1'b0;
        wait_valid("rst_pending", n);
        for (int k = 1; k <= 10; k++) step();
        check("rst_pre_pcm", 32'(pcm_out), 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_pcm", 32'(pcm_out), 32'd0);
        check("rst_async_valid", 32'(pcm_valid), 32'd0);
        check("rst_async_overrun", 32'(overrun), 32'd0);
        step();
        reset_n   = 1'b1;
        pcm_ready = 1'b1;
        wait_valid("rst_restart", n);
        check("rst_restart_latency", 32'(n), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
